timer_counter: RTL

- Memory-mapped timer/counter peripheral on the CPU data bus, downstream of the CPU's m_data_* store/load port.
- Its interrupt output feeds the CPU's external interrupt input, replacing the bench-generated interrupt pulse in system-level runs.
- Three word registers: CTRL, PRESET, COUNT.
- Programmable one-shot or auto-reload down-counting; raises a maskable interrupt when the count expires.

---
 rtl/timer_pkg.sv | 13 +
 rtl/timer_prescaler.sv | 21 ++
 rtl/timer_counter.sv | 92 +++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding, register offsets and CTRL field layout for timer_counter.
package timer_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT = 2'd2;
    localparam int CTRL_EN = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM = 3;
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD = 2'b01;
endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: modulo-PRESCALE tick generator, built only when TIMER_PRESCALE_EN is defined.
`ifdef TIMER_PRESCALE_EN
module timer_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic tick
);
    localparam int W = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    logic [W-1:0] cnt;
    assign tick = cnt == W'(PRESCALE - 1);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (run) cnt <= tick ? '0 : cnt + 1'b1;
    end
endmodule
`endif

// File: rtl/timer_counter.sv
// timer_counter: memory-mapped down-counting timer (CTRL/PRESET/COUNT) with maskable expiry irq.
// Define TIMER_PRESCALE_EN to step the count only once every PRESCALE clocks.
module timer_counter
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
    parameter int PRESCALE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);
    logic en, im, irq_flag, sel, ctrl_wr, tick;
    logic [1:0] mode;
    logic [31:0] preset, count;
    state_t state;
    logic unused_ok;
    assign sel = addr[31:4] == BASE_ADDR[31:4];
    assign ctrl_wr = sel && we && addr[3:2] == REG_CTRL;
    assign irq = irq_flag & im;
`ifdef TIMER_PRESCALE_EN
    timer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk(clk),
        .reset(reset),
        .clear(state == LOAD),
        .run(state == CNT),
        .tick(tick)
    );
    assign unused_ok = ^{addr[1:0], wdata[31:4]};
`else
    assign tick = 1'b1;
    assign unused_ok = ^{addr[1:0], wdata[31:4], 32'(PRESCALE)};
`endif
    always_comb
        rdata = !sel ? '0 :
                addr[3:2] == REG_CTRL   ? {28'd0, im, mode, en} :
                addr[3:2] == REG_PRESET ? preset :
                addr[3:2] == REG_COUNT  ? count : '0;
    // A CTRL write is applied after the FSM so it overrides the one-shot EN clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en <= 1'b0;
            mode <= MODE_ONESHOT;
            im <= 1'b0;
            preset <= '0;
            count <= '0;
            irq_flag <= 1'b0;
            state <= IDLE;
        end else begin
            if (sel && we && addr[3:2] == REG_PRESET) preset <= wdata;
            case (state)
                IDLE: if (en) state <= LOAD;
                LOAD: begin
                    count <= preset;
                    state <= CNT;
                end
                CNT: begin
                    if (!en) state <= IDLE;
                    else if (tick) begin
                        if (count > 32'd1) count <= count - 32'd1;
                        else begin
                            count <= '0;
                            irq_flag <= 1'b1;
                            state <= INT;
                        end
                    end
                end
                INT: begin
                    // Auto-reload restarts straight into LOAD, giving a LOAD,CNT..,INT period.
                    if (mode == MODE_RELOAD) begin
                        irq_flag <= 1'b0;
                        state <= en ? LOAD : IDLE;
                    end else begin
                        en <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (ctrl_wr) begin
                en <= wdata[CTRL_EN];
                mode <= wdata[CTRL_MODE_HI:CTRL_MODE_LO];
                im <= wdata[CTRL_IM];
                irq_flag <= 1'b0;
            end
        end
    end
endmodule
